// File: rtl/pipe_pkg.sv
// Shared types and constants for the issue-stage hazard scoreboard.
package pipe_pkg;

    // Slot fields are stored at fixed widths; narrower addresses/latencies are zero-extended.
    localparam int unsigned SB_RD_W   = 8;
    localparam int unsigned SB_LAT_W  = 8;
    localparam int unsigned SB_SLOT_W = 1 + SB_RD_W + SB_LAT_W;

    localparam int unsigned FWD_REGFILE = 0;
    localparam int unsigned FWD_EX_MEM  = 1;
    localparam int unsigned FWD_MEM_WB  = 2;

    typedef struct packed {
        logic                valid;
        logic [SB_RD_W-1:0]  rd;
        logic [SB_LAT_W-1:0] lat;
    } sb_slot_t;

    function automatic int unsigned age_w(input int unsigned wb_depth);
        return $clog2(wb_depth + 1);
    endfunction

endpackage

// File: rtl/sb_match.sv
// Youngest-match priority encoder over the in-flight slot vector for one source register.
module sb_match
    import pipe_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned NSLOT = 2,
    parameter int unsigned AGE_W = 2
) (
    input  logic [NSLOT*SB_SLOT_W-1:0] i_slots,
    input  logic [REG_W-1:0]           i_src,
    input  logic                       i_used,
    output logic                       o_hit,
    output logic [AGE_W-1:0]           o_k,
    output logic [SB_LAT_W-1:0]        o_lat
);

    sb_slot_t [NSLOT-1:0] w_slots;
    logic                 w_src_live;

    assign w_slots    = i_slots;
    assign w_src_live = i_used && (i_src != '0);

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        o_hit = 1'b0;
        o_k   = '0;
        o_lat = '0;
        for (int j = int'(NSLOT) - 1; j >= 0; j--) begin
            if (w_src_live && w_slots[j].valid && (w_slots[j].rd == SB_RD_W'(i_src))) begin
                o_hit = 1'b1;
                o_k   = AGE_W'(j + 1);
                o_lat = w_slots[j].lat;
            end
        end
    end

endmodule

// File: rtl/pipe_scoreboard.sv
// Issue-stage hazard scoreboard: stall, forwarding distance and flush cancellation.
// Optional statistics counters are built when SCOREBOARD_STATS_EN is defined.
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned WB_DEPTH    = 3,
    parameter int unsigned MAX_LAT     = 2,
    parameter int unsigned FLUSH_DEPTH = 2,
    localparam int unsigned AGE_W      = age_w(WB_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_advance,
    input  logic             i_issue_valid,
    input  logic [REG_W-1:0] i_issue_rs1,
    input  logic [REG_W-1:0] i_issue_rs2,
    input  logic             i_issue_rs1_used,
    input  logic             i_issue_rs2_used,
    input  logic [REG_W-1:0] i_issue_rd,
    input  logic             i_issue_we,
    input  logic [AGE_W-1:0] i_issue_lat,
    input  logic             i_flush,
    output logic             o_issue_stall,
    output logic             o_issue_fire,
    output logic [AGE_W-1:0] o_fwd_rs1,
    output logic [AGE_W-1:0] o_fwd_rs2
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]      o_stall_cnt,
    output logic [31:0]      o_flush_cnt
`endif
);

    localparam int unsigned NSLOT = WB_DEPTH - 1;

    if (WB_DEPTH < FWD_MEM_WB) begin : g_bad_depth
        $error("pipe_scoreboard: WB_DEPTH must leave at least one in-flight slot");
    end
    if (MAX_LAT < FWD_EX_MEM || MAX_LAT > WB_DEPTH) begin : g_bad_lat
        $error("pipe_scoreboard: MAX_LAT must lie in 1..WB_DEPTH");
    end
    if (FLUSH_DEPTH >= WB_DEPTH) begin : g_bad_flush
        $error("pipe_scoreboard: FLUSH_DEPTH must be below WB_DEPTH");
    end
    if (REG_W > SB_RD_W) begin : g_bad_reg_w
        $error("pipe_scoreboard: REG_W exceeds slot rd storage");
    end

    sb_slot_t [NSLOT-1:0] r_slots;
    sb_slot_t [NSLOT-1:0] w_slots_d;

    logic                w_hit1;
    logic                w_hit2;
    logic [AGE_W-1:0]    w_k1;
    logic [AGE_W-1:0]    w_k2;
    logic [SB_LAT_W-1:0] w_lat1;
    logic [SB_LAT_W-1:0] w_lat2;
    logic                w_haz1;
    logic                w_haz2;
    logic                w_stall;
    logic                w_fire;
    logic [SB_LAT_W-1:0] w_lat_norm;

    sb_match #(
        .REG_W (REG_W),
        .NSLOT (NSLOT),
        .AGE_W (AGE_W)
    ) u_match_rs1 (
        .i_slots (r_slots),
        .i_src   (i_issue_rs1),
        .i_used  (i_issue_rs1_used),
        .o_hit   (w_hit1),
        .o_k     (w_k1),
        .o_lat   (w_lat1)
    );

    sb_match #(
        .REG_W (REG_W),
        .NSLOT (NSLOT),
        .AGE_W (AGE_W)
    ) u_match_rs2 (
        .i_slots (r_slots),
        .i_src   (i_issue_rs2),
        .i_used  (i_issue_rs2_used),
        .o_hit   (w_hit2),
        .o_k     (w_k2),
        .o_lat   (w_lat2)
    );

    // A producer is not yet forwardable while its age is below its latency.
    assign w_haz1  = w_hit1 && (SB_LAT_W'(w_k1) < w_lat1);
    assign w_haz2  = w_hit2 && (SB_LAT_W'(w_k2) < w_lat2);
    assign w_stall = i_issue_valid && (w_haz1 || w_haz2);
    assign w_fire  = i_issue_valid && !w_stall && !i_flush && i_advance;

    assign o_issue_stall = w_stall;
    assign o_issue_fire  = w_fire;
    assign o_fwd_rs1     = w_hit1 ? w_k1 : AGE_W'(FWD_REGFILE);
    assign o_fwd_rs2     = w_hit2 ? w_k2 : AGE_W'(FWD_REGFILE);

    always_comb begin
        w_lat_norm = SB_LAT_W'(i_issue_lat);
        if ((i_issue_lat == '0) || (SB_LAT_W'(i_issue_lat) > SB_LAT_W'(MAX_LAT))) begin
            w_lat_norm = SB_LAT_W'(MAX_LAT);
        end
    end

    always_comb begin
        w_slots_d = r_slots;
        if (i_advance) begin
            for (int j = int'(NSLOT) - 1; j > 0; j--) begin
                w_slots_d[j] = r_slots[j-1];
            end
            w_slots_d[0].valid = w_fire && i_issue_we && (i_issue_rd != '0);
            w_slots_d[0].rd    = SB_RD_W'(i_issue_rd);
            w_slots_d[0].lat   = w_lat_norm;
        end
        // Flush kills the youngest slots after the shift, or in place when frozen.
        if (i_flush) begin
            for (int j = 0; j < int'(FLUSH_DEPTH); j++) begin
                w_slots_d[j].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_slots <= '0;
        end else begin
            r_slots <= w_slots_d;
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && i_advance && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (i_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard; counter checks are built with SCOREBOARD_STATS_EN.
module tb_pipe_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       advance;
    logic       issue_valid;
    logic [4:0] issue_rs1;
    logic [4:0] issue_rs2;
    logic       issue_rs1_used;
    logic       issue_rs2_used;
    logic [4:0] issue_rd;
    logic       issue_we;
    logic [1:0] issue_lat;
    logic       flush;
    logic       issue_stall;
    logic       issue_fire;
    logic [1:0] fwd_rs1;
    logic [1:0] fwd_rs2;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipe_scoreboard u_dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_advance        (advance),
        .i_issue_valid    (issue_valid),
        .i_issue_rs1      (issue_rs1),
        .i_issue_rs2      (issue_rs2),
        .i_issue_rs1_used (issue_rs1_used),
        .i_issue_rs2_used (issue_rs2_used),
        .i_issue_rd       (issue_rd),
        .i_issue_we       (issue_we),
        .i_issue_lat      (issue_lat),
        .i_flush          (flush),
        .o_issue_stall    (issue_stall),
        .o_issue_fire     (issue_fire),
        .o_fwd_rs1        (fwd_rs1),
        .o_fwd_rs2        (fwd_rs2)
`ifdef SCOREBOARD_STATS_EN
        ,
        .o_stall_cnt      (stall_cnt),
        .o_flush_cnt      (flush_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic we, input logic [1:0] lat);
        issue_valid    = v;
        issue_rs1      = rs1;
        issue_rs1_used = u1;
        issue_rs2      = rs2;
        issue_rs2_used = u2;
        issue_rd       = rd;
        issue_we       = we;
        issue_lat      = lat;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        advance = 1'b1;
        flush   = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
        check("reset_stall", 32'(issue_stall), 32'd0);
        check("reset_fire", 32'(issue_fire), 32'd0);
        check("reset_fwd1", 32'(fwd_rs1), 32'd0);
        check("reset_fwd2", 32'(fwd_rs2), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // add x5, then add x6 reading x5
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd1);
        check("add_x5_fire", 32'(issue_fire), 32'd1);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 2'd1);
        check("add_x6_stall", 32'(issue_stall), 32'd0);
        check("add_x6_fwd1", 32'(fwd_rs1), 32'd1);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 2'd1);
        check("pre_rst_fwd1", 32'(fwd_rs1), 32'd2);
        check("pre_rst_fwd2", 32'(fwd_rs2), 32'd1);

        // asynchronous reset mid-cycle with two live slots
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_stall", 32'(issue_stall), 32'd0);
        check("mid_rst_fwd1", 32'(fwd_rs1), 32'd0);
        check("mid_rst_fwd2", 32'(fwd_rs2), 32'd0);
        check("mid_rst_fire", 32'(issue_fire), 32'd1);
        tick();

        // ALU chain distances
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd1);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1);
        check("alu_d1_stall", 32'(issue_stall), 32'd0);
        check("alu_d1_fwd1", 32'(fwd_rs1), 32'd1);
        tick();
        check("alu_d2_fwd1", 32'(fwd_rs1), 32'd2);
        tick();
        check("alu_d3_fwd1", 32'(fwd_rs1), 32'd0);
        check("alu_d3_stall", 32'(issue_stall), 32'd0);
        tick();

        // load-use on rs2
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 2'd2);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 2'd1);
        check("lu_stall", 32'(issue_stall), 32'd1);
        check("lu_fire", 32'(issue_fire), 32'd0);
        check("lu_fwd2", 32'(fwd_rs2), 32'd1);
        tick();
        check("lu2_stall", 32'(issue_stall), 32'd0);
        check("lu2_fwd2", 32'(fwd_rs2), 32'd2);
        check("lu2_fire", 32'(issue_fire), 32'd1);
        tick();

        // x0 destination and source
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'd2);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1);
        check("x0_stall", 32'(issue_stall), 32'd0);
        check("x0_fwd1", 32'(fwd_rs1), 32'd0);
        tick();

        // unused source does not match
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'd2);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 2'd1);
        check("unused_stall", 32'(issue_stall), 32'd0);
        check("unused_fwd2", 32'(fwd_rs2), 32'd0);
        check("unused_fire", 32'(issue_fire), 32'd1);
        tick();

        // shadowing: younger x7 producer wins
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd1);
        tick();
        tick();
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1);
        check("shadow_fwd1", 32'(fwd_rs1), 32'd1);
        check("shadow_stall", 32'(issue_stall), 32'd0);
        tick();

        // latency 0 is treated as MAX_LAT
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 2'd0);
        tick();
        drive(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1);
        check("lat0_stall", 32'(issue_stall), 32'd1);
        check("lat0_fwd1", 32'(fwd_rs1), 32'd1);
        tick();
        check("lat0_2_stall", 32'(issue_stall), 32'd0);
        check("lat0_2_fwd1", 32'(fwd_rs1), 32'd2);
        tick();

        // flush kills the in-flight load
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 2'd2);
        tick();
        flush = 1'b1;
        drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1);
        check("flush_fire", 32'(issue_fire), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("post_flush_stall", 32'(issue_stall), 32'd0);
        check("post_flush_fwd1", 32'(fwd_rs1), 32'd0);
        check("post_flush_fire", 32'(issue_fire), 32'd1);
`ifdef SCOREBOARD_STATS_EN
        check("stall_cnt_a", stall_cnt, 32'd3);
        check("flush_cnt_a", flush_cnt, 32'd1);
`endif
        tick();

        // flush while frozen
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 2'd2);
        tick();
        advance = 1'b0;
        flush   = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1);
        tick();
        advance = 1'b1;
        flush   = 1'b0;
        drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1);
        check("frz_flush_fwd1", 32'(fwd_rs1), 32'd0);
        check("frz_flush_stall", 32'(issue_stall), 32'd0);
        tick();

        // freeze holds the load in slot 1
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 2'd2);
        tick();
        advance = 1'b0;
        drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1);
        for (int i = 0; i < 3; i++) begin
            check("freeze_stall", 32'(issue_stall), 32'd1);
            check("freeze_fwd1", 32'(fwd_rs1), 32'd1);
            check("freeze_fire", 32'(issue_fire), 32'd0);
            tick();
        end
        advance = 1'b1;
        #1;
        check("thaw_stall", 32'(issue_stall), 32'd1);
        check("thaw_fire", 32'(issue_fire), 32'd0);
        tick();
        check("thaw2_stall", 32'(issue_stall), 32'd0);
        check("thaw2_fwd1", 32'(fwd_rs1), 32'd2);
        check("thaw2_fire", 32'(issue_fire), 32'd1);
`ifdef SCOREBOARD_STATS_EN
        check("stall_cnt_b", stall_cnt, 32'd4);
        check("flush_cnt_b", flush_cnt, 32'd2);
`endif
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_scoreboard.md
# pipe_scoreboard

Parametrised issue-stage hazard scoreboard for the pipelined RV64 core. It sits between decode and the ID/EX buffer and tracks every in-flight register write in a shift register of issue slots. It produces a load-use/variable-latency stall, per-source forwarding distances for the EX-stage operand muxes, and branch-flush cancellation. It generalises the fixed two-source forwarding unit to N pipeline depths and per-instruction result latency.

## Interface
- REG_W, 5, register address width
- WB_DEPTH, 3, cycles from issue to register-file write (write-first regfile; age ≥ WB_DEPTH reads regfile)
- MAX_LAT, 2, maximum result latency in cycles (1 ≤ MAX_LAT ≤ WB_DEPTH)
- FLUSH_DEPTH, 2, number of youngest issued slots cancelled by flush (FLUSH_DEPTH < WB_DEPTH)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all slots
- advance  in  1  pipeline moves this cycle; 0 freezes all slots
- issue_valid  in  1  decoded instruction presented
- issue_rs1, issue_rs2  in  REG_W  source registers
- issue_rs1_used, issue_rs2_used  in  1  source actually read
- issue_rd  in  REG_W  destination
- issue_we  in  1  instruction writes rd
- issue_lat  in  AGE_W  cycles after issue until result is forwardable (1 = ALU, 2 = load); 0 or >MAX_LAT is treated as MAX_LAT
- flush  in  1  branch taken at EX/MEM; kill younger instructions
- issue_stall  out  1  RAW hazard on a used source (combinational)
- issue_fire  out  1  issue_valid & ~issue_stall & ~flush & advance
- fwd_rs1, fwd_rs2  out  AGE_W  forwarding distance: 0 = register file, k = producer issued k cycles ago (1 = EX/MEM, 2 = MEM/WB)
- stall_cnt, flush_cnt  out  32  statistics (only with SCOREBOARD_STATS_EN)

AGE_W = $clog2(WB_DEPTH+1).

## Operation
- State: slots 1..WB_DEPTH-1, each {valid, rd, lat}. Slot k holds the instruction issued k advancing cycles ago.
- When advance=1, the register shifts: slot k+1 ← slot k. Slot 1 ← {issue_fire & issue_we & (issue_rd≠0), issue_rd, issue_lat}. A stall or bubble inserts an invalid slot 1. The oldest slot drops out.
- Per source: match = valid slots with rd == source, source ≠ 0, used=1. Select the youngest match (smallest k); younger producers shadow older ones.
- Hazard on a source when the youngest match has k < lat. issue_stall = issue_valid & (hazard_rs1 | hazard_rs2).
- fwd_rsN = k of the youngest match, else 0. The output is valid even when stalled.
- flush: on the same edge, invalidate slots 1..FLUSH_DEPTH after the shift. issue_fire is forced to 0. flush applies even when advance=0.
- When advance=0, slots hold and issue_fire=0. issue_stall and fwd are still computed from the held slots.
- x0 never creates a slot and never matches.

## Timing
- Reset: all slots invalid. issue_stall=0, issue_fire=0, fwd_rs1=fwd_rs2=0, counters=0. Reset is asynchronous and may occur mid-stream; no slot survives it.
- issue_stall, issue_fire and fwd are combinational from inputs and slot state, with zero latency.
- Slot update occurs one cycle after issue_fire. The stall for a lat-L producer lasts L−1 cycles for an immediately following consumer.
- Flush and issue on the same cycle: flush wins, and no slot is created.

## Configuration
- SCOREBOARD_STATS_EN defined: stall_cnt increments each cycle with issue_stall & advance. flush_cnt increments each cycle with flush. Both saturate at 2^32−1 and are cleared by reset.
- SCOREBOARD_STATS_EN undefined: the ports are absent and no counter logic is built.

## Structure
- Shared package pipe_pkg holds:
  - the sb_slot_t struct {valid, rd, lat};
  - the AGE_W function;
  - localparams FWD_REGFILE=0, FWD_EX_MEM=1, FWD_MEM_WB=2.
- One sub-module, sb_match: a combinational youngest-match priority encoder over the slot vector, returning {hit, k, lat}. It is instantiated once per source.

## Test plan
- Reset mid-stream with 2 valid slots → next cycle stall=0, fwd_rs1=fwd_rs2=0, fire follows issue_valid.
- ALU chain: issue add x5 (lat 1), then consumer rs1=x5:
  - consumer issued the next cycle → stall=0, fwd_rs1=1;
  - consumer one cycle later → fwd_rs1=2;
  - consumer three cycles after add → fwd_rs1=0.
- Load-use: lw x6 (lat 2), consumer rs2=x6 next cycle → stall=1 for one cycle (fire=0, fwd_rs2=1), then stall=0, fwd_rs2=2.
- x0 and unused sources:
  - issue rd=x0, we=1, then consumer rs1=x0 → stall=0, fwd 0;
  - lw x9, then consumer with rs2=x9 and rs2_used=0 → stall=0.
- Shadowing: add x7, sub x7, then consumer rs1=x7 → fwd_rs1=1 (sub), stall=0.
- Flush and freeze:
  - lw x8 issued, flush next cycle → consumer rs1=x8 gives stall=0, fwd 0, flush_cnt=1;
  - advance=0 for 3 cycles after lw x8 (no flush) → fwd_rs1 stays 1 and stall is held.
